// File: rtl/t02_mem_responder_pkg.sv
// Shared types and constants for the CPU memory request path responder.
package t02_mem_responder_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [SEL_W-1:0] FETCH_SEL = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_ISSUE = 3'd1,
    I_WAIT  = 3'd2,
    D_ISSUE = 3'd3,
    D_WAIT  = 3'd4,
    SETTLE  = 3'd5
  } resp_state_e;

  // Request unit operation encoding.
  typedef enum logic [1:0] {
    CU_NONE  = 2'd0,
    CU_FETCH = 2'd1,
    CU_READ  = 2'd2,
    CU_WRITE = 2'd3
  } cu_op_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } dreq_t;

  function automatic dreq_t make_dreq(input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] wdata,
                                      input logic [SEL_W-1:0]  sel);
    dreq_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.sel   = sel;
    return r;
  endfunction

endpackage

// File: rtl/t02_mem_responder_if.sv
// Single-port memory bus between the responder (master) and the bus manager/SRAM (slave).
interface t02_mem_responder_if;
  import t02_mem_responder_pkg::*;

  logic              bus_ren;
  logic              bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [SEL_W-1:0]  bus_sel;
  logic              bus_busy;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_ren, bus_wen, bus_addr, bus_wdata, bus_sel,
    input  bus_busy, bus_rdata
  );

  modport slave (
    input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_sel,
    output bus_busy, bus_rdata
  );

endinterface

// File: rtl/t02_mem_responder.sv
// Serialises instruction fetches and data accesses onto one busy/done memory bus;
// data accesses win over fetches and every output is registered.
module t02_mem_responder
  import t02_mem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               imemRen,
  input  logic [ADDR_W-1:0]  imemaddr,
  input  logic               dmmRen,
  input  logic               dmmWen,
  input  logic [ADDR_W-1:0]  dmmaddr,
  input  logic [DATA_W-1:0]  dmmstore,
  input  logic [SEL_W-1:0]   dmmsel,
  t02_mem_responder_if.master bus,
  output logic               i_ready,
  output logic               d_ready,
  output logic [DATA_W-1:0]  imemload,
  output logic [DATA_W-1:0]  dmmload,
  output logic               mem_err
);

  resp_state_e       state_q, state_d;
  logic              pend_r_q, pend_r_d;
  logic              pend_w_q, pend_w_d;
  dreq_t             pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;

  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] imemload_q, imemload_d;
  logic [DATA_W-1:0] dmmload_q, dmmload_d;

  logic              strobe;
  logic              timeout_hit;
  dreq_t             take;
  logic              take_w;

  assign strobe      = dmmRen | dmmWen;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next state, pending capture and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    pend_r_d   = pend_r_q;
    pend_w_d   = pend_w_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    ren_d      = 1'b0;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    err_d      = 1'b0;
    imemload_d = imemload_q;
    dmmload_d  = dmmload_q;
    take       = strobe ? make_dreq(dmmaddr, dmmstore, dmmsel) : pend_q;
    take_w     = strobe ? dmmWen : pend_w_q;

    // A write strobe dominates a simultaneous read; the newest strobe wins.
    if (strobe) begin
      pend_r_d = dmmRen & ~dmmWen;
      pend_w_d = dmmWen;
      pend_d   = make_dreq(dmmaddr, dmmstore, dmmsel);
    end

    case (state_q)
      IDLE: begin
        if (strobe || pend_r_q || pend_w_q) begin
          state_d  = D_ISSUE;
          ren_d    = ~take_w;
          wen_d    = take_w;
          addr_d   = take.addr;
          wdata_d  = take.wdata;
          sel_d    = take.sel;
          wr_d     = take_w;
          cnt_d    = '0;
          pend_r_d = 1'b0;
          pend_w_d = 1'b0;
        end else if (imemRen) begin
          state_d = I_ISSUE;
          ren_d   = 1'b1;
          addr_d  = imemaddr;
          sel_d   = FETCH_SEL;
          cnt_d   = '0;
        end
      end
      I_ISSUE: state_d = I_WAIT;
      D_ISSUE: state_d = D_WAIT;
      I_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!bus.bus_busy) begin
          state_d    = SETTLE;
          i_ready_d  = 1'b1;
          imemload_d = bus.bus_rdata;
        end else if (timeout_hit) begin
          state_d    = SETTLE;
          i_ready_d  = 1'b1;
          err_d      = 1'b1;
          imemload_d = '0;
        end
      end
      D_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!bus.bus_busy) begin
          state_d   = SETTLE;
          d_ready_d = 1'b1;
          if (!wr_q) dmmload_d = bus.bus_rdata;
        end else if (timeout_hit) begin
          state_d   = SETTLE;
          d_ready_d = 1'b1;
          err_d     = 1'b1;
          dmmload_d = '0;
        end
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      pend_r_q   <= 1'b0;
      pend_w_q   <= 1'b0;
      pend_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      imemload_q <= '0;
      dmmload_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_r_q   <= pend_r_d;
      pend_w_q   <= pend_w_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
      err_q      <= err_d;
      imemload_q <= imemload_d;
      dmmload_q  <= dmmload_d;
    end
  end

  assign bus.bus_ren   = ren_q;
  assign bus.bus_wen   = wen_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_sel   = sel_q;
  assign i_ready       = i_ready_q;
  assign d_ready       = d_ready_q;
  assign mem_err       = err_q;
  assign imemload      = imemload_q;
  assign dmmload       = dmmload_q;

endmodule

// File: tb/tb_t02_mem_responder.sv
// Bench for t02_mem_responder: directed scenarios plus a randomized run against a
// transaction-level model (pending slot, one outstanding access, ready-cycle arithmetic).
module tb_t02_mem_responder;

  localparam int unsigned TMO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic [3:0]  dmmsel;
  logic        i_ready;
  logic        d_ready;
  logic [31:0] imemload;
  logic [31:0] dmmload;
  logic        mem_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  t02_mem_responder_if bus();

  t02_mem_responder #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemRen(imemRen), .imemaddr(imemaddr),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr),
    .dmmstore(dmmstore), .dmmsel(dmmsel),
    .bus(bus),
    .i_ready(i_ready), .d_ready(d_ready),
    .imemload(imemload), .dmmload(dmmload), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // Memory model: image plus latency-driven busy/rdata behaviour.
  logic [31:0] mem_img [logic [31:0]];
  int          mem_lat    = 0;
  bit          mem_active = 0;
  int          mem_cnt    = 0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  bit          mem_wr;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = mem_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_img[a] = v;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (mem_active) begin
      if (mem_cnt > 0) begin
        bus.bus_busy  = 1'b1;
        bus.bus_rdata = $urandom;
        mem_cnt--;
      end else begin
        bus.bus_busy = 1'b0;
        if (mem_wr) mem_write(mem_addr, mem_wdata, mem_sel);
        else        bus.bus_rdata = mem_read(mem_addr);
        mem_active = 0;
      end
    end else begin
      bus.bus_busy = 1'b0;
    end
    if (bus.bus_ren || bus.bus_wen) begin
      mem_active = 1;
      mem_cnt    = mem_lat;
      mem_addr   = bus.bus_addr;
      mem_wdata  = bus.bus_wdata;
      mem_sel    = bus.bus_sel;
      mem_wr     = bus.bus_wen;
    end
  endtask

  // which: 0 i_ready, 1 d_ready, 2 bus_ren, 3 bus_wen
  task automatic wait_for(input int which, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      case (which)
        0:       ok = i_ready;
        1:       ok = d_ready;
        2:       ok = bus.bus_ren;
        default: ok = bus.bus_wen;
      endcase
    end
  endtask

  task automatic quiesce();
    imemRen = 0; dmmRen = 0; dmmWen = 0; mem_lat = 0;
    repeat (14) step();
  endtask

  task automatic test_reset();
    nRST = 0; imemRen = 1; imemaddr = 32'h0000_0010;
    dmmRen = 0; dmmWen = 0; dmmaddr = 0; dmmstore = 0; dmmsel = 0;
    bus.bus_busy = 0; bus.bus_rdata = 0;
    step(); step();
    n_cmp++;
    if ({bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_wdata, bus.bus_sel,
         i_ready, d_ready, imemload, dmmload, mem_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h load=%h/%h ctl=%b expected all zero",
               bus.bus_addr, bus.bus_wdata, imemload, dmmload,
               {bus.bus_ren, bus.bus_wen, bus.bus_sel, i_ready, d_ready, mem_err});
    end
    nRST = 1;
    step();
    n_cmp++;
    if ({bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_sel} !== {1'b1, 1'b0, 32'h0000_0010, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_first_fetch: got ren=%b wen=%b addr=%h sel=%h expected 1 0 00000010 f",
               bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_sel);
    end
    step(); step();
    n_cmp++;
    if ({i_ready, imemload} !== {1'b1, 32'h0051_0093}) begin
      n_fail++;
      $display("FAIL reset_first_ready: got i_ready=%b imemload=%h expected 1 00510093", i_ready, imemload);
    end
    imemRen = 0;
  endtask

  task automatic test_fetch_wait();
    quiesce();
    mem_lat = 3; imemaddr = 32'h0000_0100; imemRen = 1;
    step();
    imemRen = 0;
    n_cmp++;
    if ({bus.bus_ren, bus.bus_addr, bus.bus_sel} !== {1'b1, 32'h0000_0100, 4'hF}) begin
      n_fail++;
      $display("FAIL fw_issue: got ren=%b addr=%h sel=%h expected 1 00000100 f", bus.bus_ren, bus.bus_addr, bus.bus_sel);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if ({i_ready, bus.bus_addr} !== {1'b0, 32'h0000_0100}) begin
        n_fail++;
        $display("FAIL fw_hold wait%0d: got i_ready=%b addr=%h expected 0 00000100", k, i_ready, bus.bus_addr);
      end
    end
    step();
    n_cmp++;
    if ({i_ready, imemload} !== {1'b1, mem_read(32'h0000_0100)}) begin
      n_fail++;
      $display("FAIL fw_ready: got i_ready=%b imemload=%h expected 1 %h", i_ready, imemload, mem_read(32'h0000_0100));
    end
    step();
    n_cmp++;
    if (i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fw_ready_width: got i_ready=%b expected 0", i_ready);
    end
  endtask

  task automatic test_data_after_fetch();
    bit ok;
    quiesce();
    imemaddr = 32'h0000_0020; imemRen = 1;
    wait_for(0, 10, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL daf_fetch_ready: got no i_ready expected one within 10 cycles"); end
    step();
    dmmRen = 1; dmmaddr = 32'h3300_0004; dmmsel = 4'hF;
    step();
    dmmRen = 0;
    n_cmp++;
    if ({bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_sel} !== {1'b1, 1'b0, 32'h3300_0004, 4'hF}) begin
      n_fail++;
      $display("FAIL daf_data_first: got ren=%b wen=%b addr=%h sel=%h expected 1 0 33000004 f",
               bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_sel);
    end
    wait_for(1, 10, ok);
    n_cmp++;
    if (!ok || dmmload !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL daf_d_ready: got ready=%b dmmload=%h expected 1 cafef00d", ok, dmmload);
    end
    wait_for(2, 10, ok);
    n_cmp++;
    if (!ok || {bus.bus_addr, bus.bus_sel} !== {32'h0000_0020, 4'hF}) begin
      n_fail++;
      $display("FAIL daf_next_fetch: got seen=%b addr=%h sel=%h expected 1 00000020 f", ok, bus.bus_addr, bus.bus_sel);
    end
    imemRen = 0;
  endtask

  task automatic test_write_during_fetch();
    bit ok;
    quiesce();
    mem_lat = 3; imemaddr = 32'h0000_0040; imemRen = 1;
    step();
    imemRen = 0;
    step();
    dmmWen = 1; dmmaddr = 32'h3300_0010; dmmstore = 32'h1234_5678; dmmsel = 4'b0011;
    step();
    dmmWen = 0; dmmstore = 32'hFFFF_FFFF; dmmsel = 4'hF;
    wait_for(0, 10, ok);
    n_cmp++;
    if (!ok || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wdf_fetch_first: got i_ready=%b d_ready=%b expected 1 0", ok, d_ready);
    end
    wait_for(3, 10, ok);
    n_cmp++;
    if (!ok || {bus.bus_ren, bus.bus_addr, bus.bus_wdata, bus.bus_sel} !==
               {1'b0, 32'h3300_0010, 32'h1234_5678, 4'b0011}) begin
      n_fail++;
      $display("FAIL wdf_write_issue: got wen=%b ren=%b addr=%h wdata=%h sel=%b expected 1 0 33000010 12345678 0011",
               ok, bus.bus_ren, bus.bus_addr, bus.bus_wdata, bus.bus_sel);
    end
    wait_for(1, 12, ok);
    n_cmp++;
    if (!ok || dmmload !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL wdf_d_ready: got ready=%b dmmload=%h expected 1 cafef00d", ok, dmmload);
    end
  endtask

  task automatic test_timeout();
    quiesce();
    mem_lat = 100; dmmRen = 1; dmmaddr = 32'h3300_0008; dmmsel = 4'hF;
    step();
    dmmRen = 0;
    n_cmp++;
    if (bus.bus_ren !== 1'b1) begin n_fail++; $display("FAIL to_issue: got ren=%b expected 1", bus.bus_ren); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if ({d_ready, mem_err} !== 2'b00) begin
        n_fail++;
        $display("FAIL to_early wait%0d: got d_ready,mem_err=%b expected 00", k, {d_ready, mem_err});
      end
    end
    step();
    n_cmp++;
    if ({d_ready, mem_err, dmmload} !== {2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL to_fire: got d_ready,mem_err=%b dmmload=%h expected 11 00000000", {d_ready, mem_err}, dmmload);
    end
    mem_active = 0; mem_lat = 0;
    imemaddr = 32'h0000_0050; imemRen = 1;
    step();
    n_cmp++;
    if ({d_ready, mem_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_pulse_width: got d_ready,mem_err=%b expected 00", {d_ready, mem_err});
    end
    step();
    imemRen = 0;
    n_cmp++;
    if ({bus.bus_ren, bus.bus_addr} !== {1'b1, 32'h0000_0050}) begin
      n_fail++;
      $display("FAIL to_back_idle: got ren=%b addr=%h expected 1 00000050", bus.bus_ren, bus.bus_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    quiesce();
    mem_lat = 5; dmmRen = 1; dmmaddr = 32'h3300_0004; dmmsel = 4'hF;
    step();
    dmmRen = 0;
    step(); step();
    nRST = 0;
    #1;
    n_cmp++;
    if ({bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_sel, d_ready, i_ready,
         dmmload, imemload, mem_err} !== '0) begin
      n_fail++;
      $display("FAIL rm_async_clear: got addr=%h load=%h/%h ctl=%b expected all zero",
               bus.bus_addr, imemload, dmmload, {bus.bus_ren, bus.bus_wen, bus.bus_sel, d_ready, i_ready, mem_err});
    end
    mem_active = 0; mem_lat = 0;
    imemaddr = 32'h0000_0010; imemRen = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if ({d_ready, bus.bus_ren} !== 2'b00) begin
        n_fail++;
        $display("FAIL rm_held: got d_ready,ren=%b expected 00", {d_ready, bus.bus_ren});
      end
    end
    nRST = 1;
    step();
    n_cmp++;
    if ({bus.bus_ren, bus.bus_addr} !== {1'b1, 32'h0000_0010}) begin
      n_fail++;
      $display("FAIL rm_resume: got ren=%b addr=%h expected 1 00000010", bus.bus_ren, bus.bus_addr);
    end
    wait_for(0, 10, ok);
    imemRen = 0;
    n_cmp++;
    if (!ok || imemload !== 32'h0051_0093) begin
      n_fail++;
      $display("FAIL rm_resume_ready: got ready=%b imemload=%h expected 1 00510093", ok, imemload);
    end
  endtask

  // Random traffic: model tracks the latest unissued data request and the one outstanding access.
  task automatic test_random();
    bit          pend_v = 0, pend_w = 0;
    logic [31:0] pend_addr, pend_wdata;
    logic [3:0]  pend_sel;
    int          pend_age = 0;
    bit          out_v = 0, out_err = 0;
    int          out_kind = 0;
    int          out_cyc = 0;
    logic [31:0] out_addr, out_wdata, out_data;
    logic [3:0]  out_sel;
    logic [31:0] exp_iload = 0, exp_dload = 0;
    bit          prev_iren = 0;
    logic [31:0] prev_iaddr = 0;
    bit          at_rdy, exp_i, exp_d, exp_e;
    int          r, lat;

    imemRen = 0; dmmRen = 0; dmmWen = 0; mem_lat = 0;
    nRST = 0; mem_active = 0; bus.bus_busy = 0;
    step();
    nRST = 1;
    for (int t = 0; t < 1600; t++) begin
      step();
      at_rdy = out_v && (cyc == out_cyc);
      exp_i  = at_rdy && out_kind == 0;
      exp_d  = at_rdy && out_kind != 0;
      exp_e  = at_rdy && out_err;
      n_cmp++;
      if ({i_ready, d_ready, mem_err} !== {exp_i, exp_d, exp_e}) begin
        n_fail++;
        $display("FAIL rnd_ready cyc%0d: got i,d,err=%b expected %b", cyc, {i_ready, d_ready, mem_err}, {exp_i, exp_d, exp_e});
      end
      if (at_rdy) begin
        if (out_kind == 0)      exp_iload = out_err ? 32'h0 : out_data;
        else if (out_kind == 1) exp_dload = out_err ? 32'h0 : out_data;
        else if (out_err)       exp_dload = 32'h0;
        out_v = 0;
      end
      n_cmp++;
      if ({imemload, dmmload} !== {exp_iload, exp_dload}) begin
        n_fail++;
        $display("FAIL rnd_loads cyc%0d: got %h/%h expected %h/%h", cyc, imemload, dmmload, exp_iload, exp_dload);
      end
      if (bus.bus_ren || bus.bus_wen) begin
        n_cmp++;
        if (out_v) begin
          n_fail++;
          $display("FAIL rnd_overlap cyc%0d: got a strobe with access outstanding expected none", cyc);
        end
        if (pend_v) begin
          out_kind = pend_w ? 2 : 1; out_addr = pend_addr; out_wdata = pend_wdata; out_sel = pend_sel;
          pend_v = 0;
        end else begin
          out_kind = 0; out_addr = prev_iaddr; out_wdata = bus.bus_wdata; out_sel = 4'hF;
          if (!prev_iren) begin
            n_fail++;
            $display("FAIL rnd_spurious cyc%0d: got strobe addr=%h expected none", cyc, bus.bus_addr);
          end
        end
        n_cmp++;
        if ({bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_sel, bus.bus_wdata} !==
            {out_kind != 2, out_kind == 2, out_addr, out_sel, out_wdata}) begin
          n_fail++;
          $display("FAIL rnd_issue cyc%0d: got ren=%b wen=%b addr=%h sel=%h wdata=%h expected kind%0d addr=%h sel=%h wdata=%h",
                   cyc, bus.bus_ren, bus.bus_wen, bus.bus_addr, bus.bus_sel, bus.bus_wdata,
                   out_kind, out_addr, out_sel, out_wdata);
        end
        lat      = mem_lat;
        out_v    = 1;
        out_err  = (lat >= int'(TMO));
        out_cyc  = cyc + (out_err ? int'(TMO) + 1 : 2 + lat);
        out_data = mem_read(out_addr);
      end else if (out_v) begin
        n_cmp++;
        if ({bus.bus_addr, bus.bus_sel} !== {out_addr, out_sel} || (out_kind == 2 && bus.bus_wdata !== out_wdata)) begin
          n_fail++;
          $display("FAIL rnd_hold cyc%0d: got addr=%h sel=%h expected %h %h", cyc, bus.bus_addr, bus.bus_sel, out_addr, out_sel);
        end
      end
      if (pend_v) begin
        pend_age++;
        n_cmp++;
        if (pend_age > 12) begin
          n_fail++;
          $display("FAIL rnd_starve cyc%0d: got request pending %0d cycles expected at most 12", cyc, pend_age);
          pend_v = 0;
        end
      end
      prev_iren = 0; dmmRen = 0; dmmWen = 0;
      imemRen = 0;
      if (t < 1500) begin
        imemRen = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 5) == 0) imemaddr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        r = $urandom_range(0, 9);
        if (r <= 2) begin
          dmmRen   = (r != 1);
          dmmWen   = (r != 0);
          dmmaddr  = 32'h3300_0000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
          dmmstore = $urandom;
          dmmsel   = 4'($urandom_range(1, 15));
          if (!pend_v) pend_age = 0;
          pend_v = 1; pend_w = dmmWen; pend_addr = dmmaddr; pend_wdata = dmmstore; pend_sel = dmmsel;
        end
      end
      prev_iren  = imemRen;
      prev_iaddr = imemaddr;
      mem_lat    = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
    end
    n_cmp++;
    if (pend_v || out_v) begin
      n_fail++;
      $display("FAIL rnd_drain: got pending=%b outstanding=%b expected 0 0", pend_v, out_v);
    end
  endtask

  initial begin
    mem_img[32'h0000_0010] = 32'h0051_0093;
    mem_img[32'h3300_0004] = 32'hCAFE_F00D;
    test_reset();
    test_fetch_wait();
    test_data_after_fetch();
    test_write_during_fetch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
